// File: rtl/ball_physics.sv
// ball_physics
//   Game-state and ball-kinematics engine feeding the frame renderer.
//   Once per frame_tick it advances the ball under gravity and resolves
//   player hits, side walls, ceiling, net and floor. It also runs the
//   serve / point-pause / game-over sequencing and keeps both scores.
//
// Ports
//   clk           system clock (same domain as the renderer)
//   reset_n       asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame, after the visible area
//   start         one-cycle pulse, starts play from IDLE or GAMEOVER
//   player_cover  renderer flag: ball overlapped P1 this frame
//   COM_cover     renderer flag: ball overlapped P2 this frame
//   ball_x/ball_y ball top-left corner, registered
//   p1_score/p2_score  0..WIN_SCORE, registered
//   score_evt     one-cycle pulse on the cycle a score changes
//   game_over     high in GAMEOVER
//   winner        0 = P1, 1 = P2, valid while game_over is high
module ball_physics #(
  parameter int GRAVITY      = 1,
  parameter int VY_MAX       = 15,
  parameter int HIT_VY       = -14,
  parameter int HIT_VX       = 6,
  parameter int BALL_SZ      = 80,
  parameter int X_MAX        = 560,
  parameter int FLOOR_Y      = 400,
  parameter int NET_L        = 314,
  parameter int NET_R        = 326,
  parameter int NET_TOP      = 300,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE1_X     = 120,
  parameter int SERVE2_X     = 440,
  parameter int SERVE_Y      = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       player_cover,
  input  logic       COM_cover,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       score_evt,
  output logic       game_over,
  output logic       winner
);

  localparam logic signed [11:0] GRAV_S    = 12'(GRAVITY);
  localparam logic signed [11:0] VY_MAX_S  = 12'(VY_MAX);
  localparam logic signed [11:0] HIT_VY_S  = 12'(HIT_VY);
  localparam logic signed [11:0] HIT_VX_S  = 12'(HIT_VX);
  localparam logic signed [11:0] BALL_S    = 12'(BALL_SZ);
  localparam logic signed [11:0] X_MAX_S   = 12'(X_MAX);
  localparam logic signed [11:0] FLOOR_S   = 12'(FLOOR_Y);
  localparam logic signed [11:0] NET_L_S   = 12'(NET_L);
  localparam logic signed [11:0] NET_R_S   = 12'(NET_R);
  localparam logic signed [11:0] NET_TOP_S = 12'(NET_TOP);
  // Ball half-width and court centre line, used for side decisions.
  localparam logic signed [11:0] HALF_S    = 12'(BALL_SZ / 2);
  localparam logic signed [11:0] MID_S     = 12'((X_MAX + BALL_SZ) / 2);
  localparam logic [3:0]         WIN_S     = 4'(WIN_SCORE);
  localparam logic [6:0]         PAUSE_END = 7'(PAUSE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_GAMEOVER} state_t;

  state_t            state, state_next;
  logic signed [11:0] vx, vx_next, vy, vy_next;
  logic [9:0]        ball_x_next, ball_y_next;
  logic [3:0]        p1_next, p2_next;
  logic              score_evt_next, game_over_next, winner_next;
  logic [6:0]        pause_cnt, pause_next;
  logic              serve, serve_next;  // 0 = P1 serves, 1 = P2 serves

  logic signed [11:0] cur_x, cur_y;
  logic signed [11:0] pvx, pvy, nx, ny, abs_vx;
  logic              land, land_left;

  assign cur_x = $signed({2'b00, ball_x});
  assign cur_y = $signed({2'b00, ball_y});

  // One physics step, evaluated every cycle but only committed on a
  // frame_tick while in PLAY.
  always_comb begin : physics
    pvx       = vx;
    pvy       = vy;
    nx        = '0;
    ny        = '0;
    abs_vx    = '0;
    land      = 1'b0;
    land_left = 1'b0;

    // Hits only count while not rising, so a ball still overlapping a
    // paddle after a hit is not struck again.
    if (!vy[11] && (player_cover || COM_cover)) begin
      pvy = HIT_VY_S;
      if (player_cover && COM_cover) pvx = '0;
      else if (player_cover)         pvx = HIT_VX_S;
      else                           pvx = -HIT_VX_S;
    end else begin
      pvy = vy + GRAV_S;
      if (pvy > VY_MAX_S) pvy = VY_MAX_S;
    end

    nx = cur_x + pvx;
    ny = cur_y + pvy;

    if (nx < 0) begin
      nx  = '0;
      pvx = -pvx;
    end else if (nx > X_MAX_S) begin
      nx  = X_MAX_S;
      pvx = -pvx;
    end

    if (ny < 0) begin
      ny  = '0;
      pvy = '0;
    end

    // Net: push the ball back to the side its previous centre was on.
    abs_vx = pvx[11] ? -pvx : pvx;
    if ((ny + BALL_S > NET_TOP_S) && (nx < NET_R_S) && (nx + BALL_S > NET_L_S)) begin
      if (cur_x + HALF_S < MID_S) begin
        nx  = NET_L_S - BALL_S;
        pvx = -abs_vx;
      end else begin
        nx  = NET_R_S;
        pvx = abs_vx;
      end
    end

    land      = (ny >= FLOOR_S);
    land_left = (nx + HALF_S < MID_S);
  end

  always_comb begin : next_state
    state_next     = state;
    ball_x_next    = ball_x;
    ball_y_next    = ball_y;
    vx_next        = vx;
    vy_next        = vy;
    p1_next        = p1_score;
    p2_next        = p2_score;
    score_evt_next = 1'b0;
    game_over_next = game_over;
    winner_next    = winner;
    pause_next     = pause_cnt;
    serve_next     = serve;

    case (state)
      S_IDLE: begin
        if (start) state_next = S_PLAY;
      end

      S_PLAY: begin
        if (frame_tick) begin
          ball_x_next = nx[9:0];
          ball_y_next = ny[9:0];
          vx_next     = pvx;
          vy_next     = pvy;
          if (land) begin
            ball_y_next    = 10'(FLOOR_Y);
            vx_next        = '0;
            vy_next        = '0;
            score_evt_next = 1'b1;
            pause_next     = '0;
            state_next     = S_POINT;
            // Landing on the left half is P2's point, and the scorer serves.
            if (land_left) begin
              p2_next    = (p2_score == WIN_S) ? p2_score : p2_score + 4'd1;
              serve_next = 1'b1;
            end else begin
              p1_next    = (p1_score == WIN_S) ? p1_score : p1_score + 4'd1;
              serve_next = 1'b0;
            end
          end
        end
      end

      S_POINT: begin
        if (frame_tick) begin
          if (pause_cnt == PAUSE_END) begin
            pause_next = '0;
            if (p1_score == WIN_S || p2_score == WIN_S) begin
              state_next     = S_GAMEOVER;
              game_over_next = 1'b1;
              winner_next    = (p2_score == WIN_S);
            end else begin
              ball_x_next = serve ? 10'(SERVE2_X) : 10'(SERVE1_X);
              ball_y_next = 10'(SERVE_Y);
              vx_next     = '0;
              vy_next     = '0;
              state_next  = S_PLAY;
            end
          end else begin
            pause_next = pause_cnt + 7'd1;
          end
        end
      end

      S_GAMEOVER: begin
        if (start) begin
          p1_next        = '0;
          p2_next        = '0;
          serve_next     = 1'b0;
          ball_x_next    = 10'(SERVE1_X);
          ball_y_next    = 10'(SERVE_Y);
          vx_next        = '0;
          vy_next        = '0;
          game_over_next = 1'b0;
          winner_next    = 1'b0;
          state_next     = S_PLAY;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ball_x    <= 10'(SERVE1_X);
      ball_y    <= 10'(SERVE_Y);
      vx        <= '0;
      vy        <= '0;
      p1_score  <= '0;
      p2_score  <= '0;
      score_evt <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      pause_cnt <= '0;
      serve     <= 1'b0;
    end else begin
      state     <= state_next;
      ball_x    <= ball_x_next;
      ball_y    <= ball_y_next;
      vx        <= vx_next;
      vy        <= vy_next;
      p1_score  <= p1_next;
      p2_score  <= p2_next;
      score_evt <= score_evt_next;
      game_over <= game_over_next;
      winner    <= winner_next;
      pause_cnt <= pause_next;
      serve     <= serve_next;
    end
  end

endmodule

// File: doc/ball_physics.md
Name: ball_physics

Overview:
- Game-state and ball-kinematics engine that sits directly upstream of the frame renderer.
- Each frame it advances the ball position under gravity and resolves wall, ceiling, net, floor and player hits.
- Player hits are detected from the renderer's per-frame contact flags (player_cover, COM_cover).
- It drives ball_x/ball_y and the two 0–9 scores consumed by the renderer, and runs serve/point/game-over sequencing.

Parameters:
- GRAVITY, 1: added to vy every frame in PLAY.
- VY_MAX, 15: vy saturation, signed.
- HIT_VY, -14: vy after a player hit.
- HIT_VX, 6: |vx| after a player hit.
- BALL_SZ, 80: ball edge length, full-res pixels.
- X_MAX, 560: rightmost ball_x (640-BALL_SZ).
- FLOOR_Y, 400: ball_y at floor contact (480-BALL_SZ).
- NET_L, 314: net left edge x. NET_R, 326: net right edge x. NET_TOP, 300: net top y.
- PAUSE_FRAMES, 60: frame ticks held in POINT.
- WIN_SCORE, 9: score that ends the game.
- SERVE1_X, 120: P1 serve x. SERVE2_X, 440: P2 serve x. SERVE_Y, 40: serve y.

Ports:
- clk  in  1  system clock, same domain as the renderer.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, asserted after the renderer finishes scanning the visible area.
- start  in  1  one-cycle pulse; begins play from IDLE or GAMEOVER.
- player_cover  in  1  renderer flag: ball overlapped P1 this frame.
- COM_cover  in  1  renderer flag: ball overlapped P2 this frame.
- ball_x  out  10  ball top-left x, 0..X_MAX.
- ball_y  out  10  ball top-left y, 0..FLOOR_Y.
- p1_score  out  4  P1 score, 0..WIN_SCORE.
- p2_score  out  4  P2 score, 0..WIN_SCORE.
- score_evt  out  1  one-cycle pulse when a point is awarded.
- game_over  out  1  high in GAMEOVER.
- winner  out  1  0=P1, 1=P2; valid while game_over is high.

Behaviour:
- Reset, asynchronous, any state, mid-frame included:
  - state=IDLE; ball_x=SERVE1_X, ball_y=SERVE_Y; vx=vy=0.
  - Scores 0; score_evt=0, game_over=0, winner=0; pause counter 0; serving side=P1.
- States and transitions:
  - IDLE: ball frozen at serve position. start -> PLAY.
  - PLAY: one physics step per frame_tick.
  - POINT: ball frozen, counts frame_ticks. At PAUSE_FRAMES: if either score == WIN_SCORE -> GAMEOVER, else place ball at the serving side's position with vx=vy=0 -> PLAY.
  - GAMEOVER: frozen. start -> scores cleared, serve=P1, ball at P1 serve -> PLAY.
- Outputs are registered. A frame_tick at cycle N produces updated ball/score outputs at cycle N+1. No update occurs without frame_tick.
- Physics step (PLAY), using signed 12-bit internal arithmetic, in this order:
  1. Hit: only if vy >= 0 (falling or level, which prevents repeated hits while still overlapping).
     - player_cover only: vx=+HIT_VX, vy=HIT_VY.
     - COM_cover only: vx=-HIT_VX, vy=HIT_VY.
     - Both: vx=0, vy=HIT_VY.
     - Otherwise: vy=min(vy+GRAVITY, VY_MAX).
  2. nx=x+vx, ny=y+vy.
  3. Side walls: nx<0 -> nx=0, vx=-vx. nx>X_MAX -> nx=X_MAX, vx=-vx.
  4. Ceiling: ny<0 -> ny=0, vy=0.
  5. Net, applied when ny+BALL_SZ > NET_TOP and the ball's x-span [nx, nx+BALL_SZ) overlaps [NET_L, NET_R):
     - Old centre (x+40) < 320 -> nx=NET_L-BALL_SZ, vx=-|vx|.
     - Otherwise -> nx=NET_R, vx=+|vx|.
     - Net checks use the post-wall nx.
  6. Floor: ny >= FLOOR_Y -> ny=FLOOR_Y, vx=vy=0, award point, go to POINT.
     - Centre nx+40 < 320 -> p2_score+1 and P2 serves next.
     - Otherwise -> p1_score+1 and P1 serves next.
     - score_evt pulses on the same cycle the score changes.
- Scores saturate at WIN_SCORE and never wrap. winner = the side that reached WIN_SCORE.
- start during PLAY or POINT is ignored. A frame_tick and start in the same cycle in IDLE: the transition to PLAY takes effect, and no physics step runs that cycle.
- player_cover/COM_cover are sampled only on frame_tick. They are ignored outside PLAY.

Test Plan:
- Reset then start, then 3 frame_ticks with no covers -> ball_x=120 throughout; ball_y=40, 41, 43, 46; vy=3.
- Drop from serve with player_cover=1 asserted on the tick where vy >= 0 -> next tick vx=+6, vy=-14; ball_x rises by 6 per tick until the wall or net; a repeated player_cover while vy<0 has no effect.
- Ball with vx=+6 at x=556 -> clamped to x=560, vx=-6; next tick x=554.
- Ball at x=230, y=280, vx=+6 (span reaches the net) -> x=234, vx=-6; no point is awarded.
- Ball lands with centre x<320 and p2_score=3 -> y=400, p2_score=4, one-cycle score_evt; after 60 ticks the ball sits at (440, 40) in PLAY.
- p1_score=8 and P1 wins a point -> p1_score=9; after 60 ticks game_over=1, winner=0; start -> scores 0, ball at (120, 40), PLAY; reset_n low mid-PLAY -> all outputs immediately at their reset values.
